// File: rtl/mdu_pkg.sv
// Shared MDU opcodes, latencies and result bundle.
// Imported by the EX-stage multiply/divide unit and its datapath.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } mdu_res_t;

  function automatic logic is_arith(
    input logic [3:0] op
  );
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mul(
    input logic [3:0] op
  );
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 32x32 multiply and divide datapath.
// Signed divide works on magnitudes so INT_MIN / -1 wraps cleanly.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output mdu_res_t    res
);

  logic        neg0;
  logic        neg1;
  logic [31:0] mag0;
  logic [31:0] mag1;
  logic [31:0] dvd;
  logic [31:0] den;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        div0;

  always_comb begin
    neg0  = in0[31];
    neg1  = in1[31];
    mag0  = neg0 ? -in0 : in0;
    mag1  = neg1 ? -in1 : in1;
    sprod = {{32{in0[31]}}, in0} * {{32{in1[31]}}, in1};
    uprod = {32'd0, in0} * {32'd0, in1};
    div0  = (in1 == 32'd0);
    dvd   = (op == MDU_DIVU) ? in0 : mag0;
    den   = (op == MDU_DIVU) ? in1 : mag1;
    // keep the divider defined on a zero divisor; result is discarded
    if (div0) begin
      den = 32'd1;
    end
    uq = dvd / den;
    ur = dvd % den;
  end

  always_comb begin
    res = '0;
    unique case (op)
      MDU_MULT: begin
        res.hi = sprod[63:32];
        res.lo = sprod[31:0];
      end
      MDU_MULTU: begin
        res.hi = uprod[63:32];
        res.lo = uprod[31:0];
      end
      MDU_DIV: begin
        res.lo   = (neg0 ^ neg1) ? -uq : uq;
        res.hi   = neg0 ? -ur : ur;
        res.div0 = div0;
      end
      MDU_DIVU: begin
        res.lo   = uq;
        res.hi   = ur;
        res.div0 = div0;
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO.
// Fixed-latency sequencing; results commit when the countdown expires.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam int MAX_LAT =
    (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [31:0]   hi_nxt;
  logic [31:0]   lo_nxt;
  mdu_res_t      pend;
  mdu_res_t      pend_nxt;
  mdu_res_t      res;
  logic          accept;

  mdu_calc u_calc (
    .op  (mdu_op),
    .in0 (in0),
    .in1 (in1),
    .res (res)
  );

  assign accept = start && !busy && is_arith(mdu_op);

  always_comb begin
    cnt_nxt  = cnt;
    hi_nxt   = hi;
    lo_nxt   = lo;
    pend_nxt = pend;
    if (busy) begin
      cnt_nxt = cnt - CW'(1);
      if (cnt == CW'(1) && !pend.div0) begin
        hi_nxt = pend.hi;
        lo_nxt = pend.lo;
      end
    end else if (start) begin
      unique case (1'b1)
        accept: begin
          pend_nxt = res;
          cnt_nxt  = is_mul(mdu_op) ? CW'(MULT_LAT)
                                    : CW'(DIV_LAT);
        end
        (mdu_op == MDU_MTHI): hi_nxt = in0;
        (mdu_op == MDU_MTLO): lo_nxt = in0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      busy <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      pend <= '0;
    end else begin
      cnt  <= cnt_nxt;
      busy <= (cnt_nxt != '0);
      hi   <= hi_nxt;
      lo   <= lo_nxt;
      pend <= pend_nxt;
    end
  end

  always_comb begin
    rd_data = '0;
    unique case (mdu_op)
      MDU_MFHI: rd_data = hi;
      MDU_MFLO: rd_data = lo;
      default:  rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit with a reference model of HI/LO
// and commit timing, plus literal spot checks.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int ML = MULT_LAT_DEF;
  localparam int DL = DIV_LAT_DEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  mdu_op = MDU_NONE;
  logic [31:0] in0 = '0;
  logic [31:0] in1 = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  int n_vec = 0;
  int n_err = 0;

  mdu_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .mdu_op  (mdu_op),
    .in0     (in0),
    .in1     (in1),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an accepted op commits at edge (accept + LAT)
  longint      cyc = 0;
  longint      done = 0;
  logic        armed = 1'b0;
  logic        m_ok = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi = '0;
  logic [31:0] p_lo = '0;
  logic        p_z = 1'b0;

  always @(posedge clk) begin
    longint a;
    longint b;
    logic [63:0] p;
    cyc++;
    if (reset) begin
      m_hi  = '0;
      m_lo  = '0;
      done  = 0;
      armed = 1'b0;
      m_ok  = 1'b1;
    end else if (armed && cyc == done) begin
      if (!p_z) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      armed = 1'b0;
    end else if (!(cyc - 1 < done) && start) begin
      p_z = 1'b0;
      case (mdu_op)
        MDU_MULT, MDU_DIV: begin
          a = longint'(signed'(in0));
          b = longint'(signed'(in1));
        end
        default: begin
          a = longint'({32'd0, in0});
          b = longint'({32'd0, in1});
        end
      endcase
      case (mdu_op)
        MDU_MULT, MDU_MULTU: begin
          p = 64'(a * b);
          p_hi = p[63:32];
          p_lo = p[31:0];
          done = cyc + ML;
          armed = 1'b1;
        end
        MDU_DIV, MDU_DIVU: begin
          p_z = (b == 0);
          if (b != 0) begin
            p_lo = 32'(a / b);
            p_hi = 32'(a % b);
          end
          done = cyc + DL;
          armed = 1'b1;
        end
        MDU_MTHI: m_hi = in0;
        MDU_MTLO: m_lo = in0;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_rd;
    if (m_ok) begin
      exp_rd = (mdu_op == MDU_MFHI) ? m_hi :
               (mdu_op == MDU_MFLO) ? m_lo : 32'd0;
      check("busy", {31'd0, busy}, {31'd0, cyc < done});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("rd_data", rd_data, exp_rd);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    start  = 1'b1;
    mdu_op = op;
    in0    = a;
    in1    = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = MDU_NONE;
  endtask

  task automatic expect_hl(input string name,
                           input logic [31:0] eh,
                           input logic [31:0] el);
    check({name, ".hi"}, hi, eh);
    check({name, ".lo"}, lo, el);
  endtask

  initial begin
    idle(2);
    reset = 1'b0;
    idle(3);
    expect_hl("reset", 32'h0, 32'h0);
    check("reset.busy", {31'd0, busy}, 32'd0);
    check("reset.rd", rd_data, 32'h0);

    issue(MDU_MULT, 32'hFFFFFFFE, 32'd3);
    idle(ML - 1);
    check("mult.busy_last", {31'd0, busy}, 32'd1);
    expect_hl("mult.old", 32'h0, 32'h0);
    idle(1);
    check("mult.busy_drop", {31'd0, busy}, 32'd0);
    expect_hl("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

    issue(MDU_MULTU, 32'hFFFFFFFE, 32'd3);
    idle(ML);
    expect_hl("multu", 32'h00000002, 32'hFFFFFFFA);

    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2);
    idle(DL - 1);
    check("div.busy_last", {31'd0, busy}, 32'd1);
    idle(1);
    expect_hl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);

    issue(MDU_DIVU, 32'd7, 32'd2);
    idle(DL);
    expect_hl("divu", 32'd1, 32'd3);

    issue(MDU_MTHI, 32'h11, 32'd0);
    issue(MDU_MTLO, 32'h22, 32'd0);
    issue(MDU_DIV, 32'd5, 32'd0);
    idle(DL - 1);
    check("div0.busy", {31'd0, busy}, 32'd1);
    idle(1);
    check("div0.drop", {31'd0, busy}, 32'd0);
    expect_hl("div0", 32'h11, 32'h22);

    issue(MDU_MTHI, 32'hDEADBEEF, 32'd0);
    check("mthi.busy", {31'd0, busy}, 32'd0);
    start  = 1'b1;
    mdu_op = MDU_MFHI;
    #1;
    check("mfhi.rd", rd_data, 32'hDEADBEEF);
    mdu_op = MDU_MFLO;
    #1;
    check("mflo.rd", rd_data, 32'h22);
    @(posedge clk);
    #1;
    start  = 1'b0;
    mdu_op = MDU_NONE;

    issue(MDU_MULT, 32'd5, 32'd6);
    idle(1);
    issue(MDU_MTLO, 32'h55, 32'd0);
    idle(ML - 3);
    check("mtlo_busy.old", lo, 32'h22);
    idle(1);
    expect_hl("mtlo_busy", 32'h0, 32'd30);

    issue(MDU_DIV, 32'd100, 32'd7);
    idle(1);
    issue(MDU_MULT, 32'd3, 32'd3);
    idle(DL - 3);
    check("overlap.busy", {31'd0, busy}, 32'd1);
    idle(1);
    check("overlap.drop", {31'd0, busy}, 32'd0);
    expect_hl("overlap", 32'd2, 32'd14);

    issue(MDU_MULT, 32'd2, 32'd2);
    idle(2);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("abort.busy", {31'd0, busy}, 32'd0);
    expect_hl("abort", 32'h0, 32'h0);
    idle(ML + 2);
    expect_hl("abort.late", 32'h0, 32'h0);

    issue(MDU_MTHI, 32'h1, 32'd0);
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    idle(DL);
    expect_hl("intmin", 32'h0, 32'h80000000);

    issue(4'hF, 32'h9, 32'h9);
    issue(MDU_NONE, 32'h9, 32'h9);
    check("unknown.busy", {31'd0, busy}, 32'd0);
    expect_hl("unknown", 32'h0, 32'h80000000);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
